// File: rtl/lsu_bank_ctrl.sv
// Load/store front end for a 2 KiB byte space split over even/odd byte banks.
// Stores write same-cycle. Loads return one cycle later, with a hold stage for response back-pressure.
module lsu_bank_ctrl (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic        i_req_we,
   input  logic [10:0] i_req_addr,
   input  logic [1:0]  i_req_size,
   input  logic        i_req_unsigned,
   input  logic [31:0] i_req_wdata,
   output logic [9:0]  o_addr_even_1,
   output logic [9:0]  o_addr_even_2,
   output logic [9:0]  o_addr_odd_1,
   output logic [9:0]  o_addr_odd_2,
   output logic [7:0]  o_data_even_1,
   output logic [7:0]  o_data_even_2,
   output logic [7:0]  o_data_odd_1,
   output logic [7:0]  o_data_odd_2,
   output logic        o_we_even_1,
   output logic        o_we_even_2,
   output logic        o_we_odd_1,
   output logic        o_we_odd_2,
   output logic        o_lsu_addr,
   input  logic [31:0] i_mem_data,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_rdata,
   output logic        o_rsp_err,
   output logic [1:0]  o_dbg_state
);

   // Handshake: a request transfers on a cycle where i_req_valid & o_req_ready;
   // a response transfers on a cycle where o_rsp_valid & i_rsp_ready.
   typedef enum logic [1:0] {IDLE = 2'd0, RESP = 2'd1, HOLD = 2'd2} state_t;

   state_t            state_q, state_d;
   logic              accept, store_acc, load_acc;
   logic [9:0]        w, w_p1, w_p2;
   logic [3:0]        lane_mask, lane_we;
   logic [3:0][7:0]   lane_data;
   logic              r_a0, r_uns;
   logic [1:0]        r_size;
   logic [31:0]       hold_rdata, live_rdata;
   logic              hold_err, live_err;

   assign accept    = i_req_valid & o_req_ready;
   assign store_acc = accept & i_req_we;
   assign load_acc  = accept & ~i_req_we;
   assign o_dbg_state = state_q;

   // Bank addressing and lane routing
   always_comb begin
      w    = i_req_addr[10:1];
      w_p1 = w + 10'd1;
      w_p2 = w + 10'd2;
      lane_mask = 4'b0000;
      case (i_req_size)
         2'b00:   lane_mask = 4'b0001;
         2'b01:   lane_mask = 4'b0011;
         2'b10:   lane_mask = 4'b1111;
         default: lane_mask = 4'b0000;
      endcase
      lane_we = store_acc ? lane_mask : 4'b0000;
      for (int k = 0; k < 4; k++)
         lane_data[k] = lane_we[k] ? i_req_wdata[8*k +: 8] : 8'h00;
      if (!i_req_addr[0]) begin
         o_addr_even_1 = w;    o_addr_odd_1 = w;
         o_addr_even_2 = w_p1; o_addr_odd_2 = w_p1;
         o_we_even_1 = lane_we[0]; o_data_even_1 = lane_data[0];
         o_we_odd_1  = lane_we[1]; o_data_odd_1  = lane_data[1];
         o_we_even_2 = lane_we[2]; o_data_even_2 = lane_data[2];
         o_we_odd_2  = lane_we[3]; o_data_odd_2  = lane_data[3];
      end else begin
         o_addr_odd_1  = w;    o_addr_even_1 = w_p1;
         o_addr_odd_2  = w_p1; o_addr_even_2 = w_p2;
         o_we_odd_1  = lane_we[0]; o_data_odd_1  = lane_data[0];
         o_we_even_1 = lane_we[1]; o_data_even_1 = lane_data[1];
         o_we_odd_2  = lane_we[2]; o_data_odd_2  = lane_data[2];
         o_we_even_2 = lane_we[3]; o_data_even_2 = lane_data[3];
      end
   end

   // Load result formatting from lane-ordered memory data
   always_comb begin
      live_rdata = 32'h0;
      live_err   = 1'b0;
      case (r_size)
         2'b00: live_rdata = r_uns ? {24'h0, i_mem_data[7:0]}
                                   : {{24{i_mem_data[7]}}, i_mem_data[7:0]};
         2'b01: live_rdata = r_uns ? {16'h0, i_mem_data[15:0]}
                                   : {{16{i_mem_data[15]}}, i_mem_data[15:0]};
         2'b10: live_rdata = i_mem_data;
         default: live_err = 1'b1;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      o_req_ready = 1'b0;
      o_rsp_valid = 1'b0;
      o_rsp_rdata = 32'h0;
      o_rsp_err   = 1'b0;
      case (state_q)
         IDLE: begin
            o_req_ready = 1'b1;
            if (load_acc) state_d = RESP;
         end
         RESP: begin
            o_req_ready = i_rsp_ready;
            o_rsp_valid = 1'b1;
            o_rsp_rdata = live_rdata;
            o_rsp_err   = live_err;
            if (!i_rsp_ready)  state_d = HOLD;
            else if (load_acc) state_d = RESP;
            else               state_d = IDLE;
         end
         HOLD: begin
            o_rsp_valid = 1'b1;
            o_rsp_rdata = hold_rdata;
            o_rsp_err   = hold_err;
            if (i_rsp_ready) state_d = load_acc ? RESP : IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Reset overrides the outputs immediately, not only after the next edge
      if (i_reset) begin
         o_req_ready = 1'b0;
         o_rsp_valid = 1'b0;
         o_rsp_rdata = 32'h0;
         o_rsp_err   = 1'b0;
      end
   end

   assign o_lsu_addr = i_reset ? 1'b0 : r_a0;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q    <= IDLE;
         r_a0       <= 1'b0;
         r_size     <= 2'b00;
         r_uns      <= 1'b0;
         hold_rdata <= 32'h0;
         hold_err   <= 1'b0;
      end else begin
         state_q <= state_d;
         if (load_acc) begin
            r_a0   <= i_req_addr[0];
            r_size <= i_req_size;
            r_uns  <= i_req_unsigned;
         end
         if (state_q == RESP && !i_rsp_ready) begin
            hold_rdata <= live_rdata;
            hold_err   <= live_err;
         end
      end
   end

endmodule

// File: tb/tb_lsu_bank_ctrl.sv
// Directed plus random stimulus for lsu_bank_ctrl with a byte-memory model and response scoreboard.
module tb_lsu_bank_ctrl;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b0;
   logic        i_req_valid = 1'b0, i_req_we = 1'b0, i_req_unsigned = 1'b0;
   logic [10:0] i_req_addr = '0;
   logic [1:0]  i_req_size = '0;
   logic [31:0] i_req_wdata = '0, i_mem_data = '0;
   logic        i_rsp_ready = 1'b0;
   logic        o_req_ready, o_lsu_addr, o_rsp_valid, o_rsp_err;
   logic [9:0]  o_addr_even_1, o_addr_even_2, o_addr_odd_1, o_addr_odd_2;
   logic [7:0]  o_data_even_1, o_data_even_2, o_data_odd_1, o_data_odd_2;
   logic        o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2;
   logic [31:0] o_rsp_rdata;
   logic [1:0]  o_dbg_state;

   lsu_bank_ctrl dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
      .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
      .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
      .o_addr_even_1(o_addr_even_1), .o_addr_even_2(o_addr_even_2),
      .o_addr_odd_1(o_addr_odd_1), .o_addr_odd_2(o_addr_odd_2),
      .o_data_even_1(o_data_even_1), .o_data_even_2(o_data_even_2),
      .o_data_odd_1(o_data_odd_1), .o_data_odd_2(o_data_odd_2),
      .o_we_even_1(o_we_even_1), .o_we_even_2(o_we_even_2),
      .o_we_odd_1(o_we_odd_1), .o_we_odd_2(o_we_odd_2),
      .o_lsu_addr(o_lsu_addr), .i_mem_data(i_mem_data), .o_rsp_valid(o_rsp_valid),
      .i_rsp_ready(i_rsp_ready), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
      .o_dbg_state(o_dbg_state)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;
   logic [33:0] exp_q[$];          // {lsu_addr, err, rdata}
   logic [7:0]  mem [2048];
   logic [31:0] mem_next = '0;
   logic        held = 1'b0;

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz, input logic uns);
      case (sz)
         2'd0:    return uns ? {24'h0, d[7:0]} : {{24{d[7]}}, d[7:0]};
         2'd1:    return uns ? {16'h0, d[15:0]} : {{16{d[15]}}, d[15:0]};
         2'd2:    return d;
         default: return 32'h0;
      endcase
   endfunction

   // One cycle: drive at posedge+1, check after settling, then advance.
   task automatic step(input logic v, input logic we, input logic [10:0] a, input logic [1:0] sz,
                       input logic uns, input logic [31:0] wd, input logic rr);
      logic        acc, exp_ready, model_valid;
      logic [10:0] b;
      logic [9:0]  ea [4];
      logic [7:0]  ed [4];
      logic        ew [4];
      logic [9:0]  da [4];
      logic [7:0]  dd [4];
      logic        dw [4];
      logic [33:0] e;
      int          p, nb;
      i_req_valid = v; i_req_we = we; i_req_addr = a; i_req_size = sz;
      i_req_unsigned = uns; i_req_wdata = wd; i_rsp_ready = rr; i_mem_data = mem_next;
      #1;
      model_valid = (exp_q.size() != 0);
      exp_ready = !model_valid || (!held && rr);
      chk("req_ready", o_req_ready, exp_ready);
      acc = v && o_req_ready;
      chk("rsp_valid", o_rsp_valid, model_valid);
      if (o_rsp_valid && model_valid) begin
         e = exp_q[0];
         chk("lsu_addr", o_lsu_addr, e[33]);
         chk("rsp_err", o_rsp_err, e[32]);
         chk("rsp_rdata", o_rsp_rdata, e[31:0]);
         if (rr) void'(exp_q.pop_front());
      end
      held = model_valid && !rr;
      da[0] = o_addr_even_1; da[1] = o_addr_even_2; da[2] = o_addr_odd_1; da[3] = o_addr_odd_2;
      dd[0] = o_data_even_1; dd[1] = o_data_even_2; dd[2] = o_data_odd_1; dd[3] = o_data_odd_2;
      dw[0] = o_we_even_1;   dw[1] = o_we_even_2;   dw[2] = o_we_odd_1;   dw[3] = o_we_odd_2;
      nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
      for (int k = 0; k < 4; k++) begin
         b = a + 11'(k);
         p = (b[0] ? 2 : 0) + (k >= 2 ? 1 : 0);
         ea[p] = b[10:1];
         ew[p] = acc && we && (k < nb);
         ed[p] = ew[p] ? wd[8*k +: 8] : 8'h00;
      end
      for (int p2 = 0; p2 < 4; p2++) begin
         if (v) chk($sformatf("bank_addr%0d a=%h", p2, a), da[p2], ea[p2]);
         chk($sformatf("bank_we%0d a=%h", p2, a), dw[p2], v ? ew[p2] : 1'b0);
         chk($sformatf("bank_data%0d a=%h", p2, a), dd[p2], v ? ed[p2] : 8'h00);
      end
      if (acc && we) begin
         for (int k = 0; k < nb; k++) mem[a + 11'(k)] = wd[8*k +: 8];
      end
      if (acc && !we) begin
         mem_next = {mem[a + 11'd3], mem[a + 11'd2], mem[a + 11'd1], mem[a]};
         exp_q.push_back({a[0], sz == 2'd3, fmt(mem_next, sz, uns)});
      end else begin
         mem_next = $urandom;
      end
      @(posedge i_clk); #1;
   endtask

   task automatic do_reset(input logic rr);
      i_reset = 1'b1; i_req_valid = 1'b1; i_req_we = 1'b1; i_req_size = 2'd2;
      i_rsp_ready = rr;
      #1;
      chk("rst_rsp_valid", o_rsp_valid, 1'b0);
      chk("rst_req_ready", o_req_ready, 1'b0);
      chk("rst_rdata", o_rsp_rdata, 32'h0);
      chk("rst_err", o_rsp_err, 1'b0);
      chk("rst_lsu_addr", o_lsu_addr, 1'b0);
      chk("rst_we", {o_we_even_1, o_we_even_2, o_we_odd_1, o_we_odd_2}, 4'h0);
      @(posedge i_clk); #1;
      chk("rst_state", o_dbg_state, 2'd0);
      i_reset = 1'b0; i_req_valid = 1'b0;
      exp_q.delete();
      held = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      @(posedge i_clk); #1;
      do_reset(1'b0);
      do_reset(1'b1);
      // word store at odd address, then read it back
      step(1, 1, 11'h005, 2'd2, 0, 32'h11223344, 1);
      step(1, 0, 11'h005, 2'd2, 0, 32'h0, 1);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // signed/unsigned byte load of 0x80
      step(1, 1, 11'h003, 2'd0, 0, 32'hAAAAAA80, 1);
      step(1, 0, 11'h003, 2'd0, 0, 32'h0, 1);
      step(1, 0, 11'h003, 2'd0, 1, 32'h0, 1);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // wrap-around at top of space
      step(1, 1, 11'h7FF, 2'd2, 0, 32'hCAFEF00D, 1);
      step(1, 0, 11'h7FF, 2'd2, 0, 32'h0, 1);
      step(1, 0, 11'h7FE, 2'd1, 0, 32'h0, 1);
      // back-pressure into HOLD, then release
      step(1, 0, 11'h010, 2'd1, 0, 32'h0, 1);
      for (int i = 0; i < 3; i++) step(1, 0, 11'h040, 2'd2, 0, 32'h0, 0);
      chk("hold_state", o_dbg_state, 2'd2);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      chk("after_hold_state", o_dbg_state, 2'd0);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // back-to-back half loads
      for (int i = 0; i < 4; i++) step(1, 0, 11'(i), 2'd1, 0, 32'h0, 1);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // store accepted while a response is in flight
      step(1, 0, 11'h020, 2'd2, 0, 32'h0, 1);
      step(1, 1, 11'h021, 2'd2, 0, 32'h55667788, 1);
      step(1, 0, 11'h021, 2'd2, 0, 32'h0, 1);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // illegal size
      step(1, 1, 11'h030, 2'd3, 0, 32'hFFFFFFFF, 1);
      step(1, 0, 11'h030, 2'd3, 0, 32'h0, 1);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // reset while a response is pending
      step(1, 0, 11'h031, 2'd0, 0, 32'h0, 1);
      do_reset(1'b0);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      step(1, 0, 11'h032, 2'd0, 0, 32'h0, 0);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 0);
      do_reset(1'b0);
      step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      // random mix
      for (int i = 0; i < 300; i++)
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 11'($urandom),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
              $urandom_range(0, 3) != 0);
      for (int i = 0; i < 3; i++) step(0, 0, 11'h000, 2'd0, 0, 32'h0, 1);
      chk("drain_empty", 34'(exp_q.size()), 34'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
